// File: rtl/ws2812_pkg.sv
// Shared types and default timing for the WS2812 pixel serializer.
// Defaults assume a 50 MHz system clock.
package ws2812_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int DEF_T0H        = 20;
    localparam int DEF_T1H        = 40;
    localparam int DEF_TBIT       = 63;
    localparam int DEF_TRESET     = 2500;
    localparam int DEF_FIFO_DEPTH = 4;

    // Pixel word layout as held in the display-buffer data PIO: G, R, B.
    localparam int PIX_W   = 24;
    localparam int FIELD_W = 8;
    localparam int G_LSB   = 16;
    localparam int R_LSB   = 8;
    localparam int B_LSB   = 0;
    localparam int PIX_MSB = PIX_W - 1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws2812_pixel_serializer_pixel_fifo.sv
// Small synchronous pixel FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module pixel_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_rdata,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/ws2812_pixel_serializer.sv
// Queues pixel words on push-bit rising edges and serialises them MSB first
// as WS2812 NRZ pulses; a latch-bit rising edge inserts the low reset gap.
module ws2812_pixel_serializer
    import ws2812_pkg::*;
#(
    parameter int T0H        = DEF_T0H,
    parameter int T1H        = DEF_T1H,
    parameter int TBIT       = DEF_TBIT,
    parameter int TRESET     = DEF_TRESET,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [23:0]                 pixel_data,
    input  logic                        pixel_push,
    input  logic                        frame_latch,
    input  logic                        overflow_clr,
    output logic                        led_dout,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy,
    output logic                        overflow,
    output logic [1:0]                  dbg_state
);
    localparam int CNT_W = $clog2(max2(TBIT, TRESET));
    localparam logic [CNT_W-1:0] C_T0H_END    = CNT_W'(T0H - 1);
    localparam logic [CNT_W-1:0] C_T1H_END    = CNT_W'(T1H - 1);
    localparam logic [CNT_W-1:0] C_TBIT_END   = CNT_W'(TBIT - 1);
    localparam logic [CNT_W-1:0] C_TRESET_END = CNT_W'(TRESET - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       r_bit_idx;
    logic [PIX_W-1:0] r_sreg;
    logic             r_led;
    logic             r_push_q;
    logic             r_latch_q;
    logic             r_armed;
    logic             r_latch_pending;
    logic             r_overflow;

    logic             w_push_evt;
    logic             w_latch_evt;
    logic             w_bit_end;
    logic             w_pop;
    logic             w_drop;
    logic             w_full;
    logic             w_empty;
    logic [PIX_W-1:0] w_rdata;
    logic [CNT_W-1:0] w_high_end;

    // r_armed blocks the first cycle after reset so levels already high
    // at deassert are not mistaken for rising edges.
    assign w_push_evt  = pixel_push  & ~r_push_q  & r_armed;
    assign w_latch_evt = frame_latch & ~r_latch_q & r_armed;
    assign w_bit_end   = (r_state == ST_LOW) && (r_cnt == C_TBIT_END);
    assign w_pop       = !w_empty && ((r_state == ST_IDLE) ||
                                      (w_bit_end && (r_bit_idx == 5'd0)));
    assign w_drop      = w_push_evt && w_full && !w_pop;
    assign w_high_end  = r_sreg[PIX_MSB] ? C_T1H_END : C_T0H_END;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push_evt),
        .i_wdata (pixel_data),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_push_q   <= 1'b0;
            r_latch_q  <= 1'b0;
            r_armed    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_push_q  <= pixel_push;
            r_latch_q <= frame_latch;
            r_armed   <= 1'b1;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_bit_idx       <= 5'd0;
            r_sreg          <= '0;
            r_led           <= 1'b0;
            r_latch_pending <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_sreg    <= w_rdata;
                        r_bit_idx <= 5'd23;
                        r_cnt     <= '0;
                        r_led     <= 1'b1;
                        r_state   <= ST_HIGH;
                    end else if (r_latch_pending) begin
                        r_latch_pending <= 1'b0;
                        r_cnt           <= '0;
                        r_led           <= 1'b0;
                        r_state         <= ST_GAP;
                    end
                end
                ST_HIGH: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == w_high_end) begin
                        r_led   <= 1'b0;
                        r_state <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx != 5'd0) begin
                            r_sreg    <= {r_sreg[PIX_MSB-1:0], 1'b0};
                            r_bit_idx <= r_bit_idx - 5'd1;
                            r_led     <= 1'b1;
                            r_state   <= ST_HIGH;
                        end else if (!w_empty) begin
                            // Back-to-back pixel: next MSB follows with no gap.
                            r_sreg    <= w_rdata;
                            r_bit_idx <= 5'd23;
                            r_led     <= 1'b1;
                            r_state   <= ST_HIGH;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (r_cnt == C_TRESET_END) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_led   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
            if (w_latch_evt) begin
                r_latch_pending <= 1'b1;
            end
        end
    end

    assign led_dout  = r_led;
    assign overflow  = r_overflow;
    assign busy      = !w_empty || (r_state != ST_IDLE) || r_latch_pending;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ws2812_pixel_serializer.sv
// Directed bench for ws2812_pixel_serializer: a pixel-timeline model is checked
// against the DUT every cycle, plus literal timing checks per scenario.
module tb_ws2812_pixel_serializer;
    localparam int T0H     = 20;
    localparam int T1H     = 40;
    localparam int TBIT    = 63;
    localparam int TRESET  = 2500;
    localparam int DEPTH   = 4;
    localparam int PIX_CYC = 24 * TBIT;

    logic        clk          = 1'b0;
    logic        reset_n      = 1'b0;
    logic [23:0] pixel_data   = '0;
    logic        pixel_push   = 1'b0;
    logic        frame_latch  = 1'b0;
    logic        overflow_clr = 1'b0;
    logic        led_dout;
    logic [2:0]  fifo_level;
    logic        busy;
    logic        overflow;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    always #10 clk = ~clk;

    ws2812_pixel_serializer #(
        .T0H        (T0H),
        .T1H        (T1H),
        .TBIT       (TBIT),
        .TRESET     (TRESET),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pixel_data   (pixel_data),
        .pixel_push   (pixel_push),
        .frame_latch  (frame_latch),
        .overflow_clr (overflow_clr),
        .led_dout     (led_dout),
        .fifo_level   (fifo_level),
        .busy         (busy),
        .overflow     (overflow),
        .dbg_state    (dbg_state)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a pixel is a 1512-cycle timeline; the line level at position p
    // follows from which bit p falls in and how far into that bit it is.
    logic [23:0] m_q [$];
    logic [23:0] m_pix        = '0;
    bit          m_active     = 0;
    bit          m_gap        = 0;
    bit          m_pend       = 0;
    bit          m_ovf        = 0;
    bit          m_armed      = 0;
    bit          m_prev_push  = 0;
    bit          m_prev_latch = 0;
    int          m_pos        = 0;
    int          m_gap_cnt    = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_active = 0; m_gap = 0; m_pend = 0; m_ovf = 0;
            m_armed = 0; m_prev_push = 0; m_prev_latch = 0;
            m_pos = 0; m_gap_cnt = 0;
        end else begin
            bit push_evt;
            bit latch_evt;
            push_evt  = m_armed && pixel_push && !m_prev_push;
            latch_evt = m_armed && frame_latch && !m_prev_latch;
            if (m_active) begin
                m_pos++;
                if (m_pos == PIX_CYC) begin
                    if (m_q.size() > 0) begin
                        m_pix = m_q.pop_front();
                        m_pos = 0;
                    end else begin
                        m_active = 0;
                    end
                end
            end else if (m_gap) begin
                m_gap_cnt++;
                if (m_gap_cnt == TRESET) m_gap = 0;
            end else if (m_q.size() > 0) begin
                m_pix    = m_q.pop_front();
                m_pos    = 0;
                m_active = 1;
            end else if (m_pend) begin
                m_pend    = 0;
                m_gap     = 1;
                m_gap_cnt = 0;
            end
            if (overflow_clr) m_ovf = 0;
            if (push_evt) begin
                if (m_q.size() < DEPTH) m_q.push_back(pixel_data);
                else m_ovf = 1;
            end
            if (latch_evt) m_pend = 1;
            m_prev_push  = pixel_push;
            m_prev_latch = frame_latch;
            m_armed      = 1;
        end
    end

    function automatic int exp_led();
        int bitn;
        int off;
        if (!m_active) return 0;
        bitn = 23 - m_pos / TBIT;
        off  = m_pos % TBIT;
        return (off < (m_pix[bitn] ? T1H : T0H)) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        check("cmp led_dout", int'(led_dout), exp_led());
        check("cmp fifo_level", int'(fifo_level), m_q.size());
        check("cmp busy", int'(busy), int'(m_active || m_gap || m_pend || (m_q.size() > 0)));
        check("cmp overflow", int'(overflow), int'(m_ovf));
    end

    bit cap_led [$];

    task automatic push_pixel(input logic [23:0] d);
        @(negedge clk);
        pixel_data = d;
        pixel_push = 1'b1;
        @(negedge clk);
        pixel_push = 1'b0;
    endtask

    task automatic capture(input int n);
        cap_led.delete();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            cap_led.push_back(led_dout);
        end
    endtask

    task automatic check_bits(input string name, input logic [47:0] word, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            int hi;
            int lead;
            int exp_w;
            bit run;
            hi = 0; lead = 0; run = 1;
            for (int j = 0; j < TBIT; j++) begin
                if (cap_led[k*TBIT + j]) begin
                    hi++;
                    if (run) lead++;
                end else begin
                    run = 0;
                end
            end
            exp_w = word[nbits-1-k] ? T1H : T0H;
            check($sformatf("%s bit%0d high width", name, k), (hi == lead) ? hi : -1, exp_w);
        end
    endtask

    task automatic wait_busy_low(input string name, input int bound);
        int k;
        k = 0;
        while (busy && k < bound) begin
            @(negedge clk);
            k++;
        end
        check(name, int'(busy), 0);
    endtask

    initial begin
        int t;
        int last_rise;
        int hi_after;
        bit prev;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset led_dout", led_dout, 0);
        check("reset fifo_level", fifo_level, 0);
        check("reset busy", busy, 0);
        check("reset overflow", overflow, 0);
        check("reset state", dbg_state, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single pixel 0xFF0000
        push_pixel(24'hFF0000);
        check("t1 level after write", fifo_level, 1);
        check("t1 led before rise", led_dout, 0);
        @(negedge clk);
        check("t1 led rises one edge after write", led_dout, 1);
        capture(PIX_CYC);
        check_bits("t1", {24'h0, 24'hFF0000}, 24);
        check("t1 busy at last cycle", busy, 1);
        @(negedge clk);
        check("t1 busy falls 1512 after rise", busy, 0);
        check("t1 led idle", led_dout, 0);
        repeat (5) @(negedge clk);

        // Back-to-back pixels 0x000001 then 0x800000
        push_pixel(24'h000001);
        @(negedge clk);
        check("t2 first rise", led_dout, 1);
        pixel_data = 24'h800000;
        pixel_push = 1'b1;
        capture(2 * PIX_CYC);
        pixel_push = 1'b0;
        check_bits("t2", {24'h000001, 24'h800000}, 48);
        @(negedge clk);
        check("t2 busy falls after 48 bits", busy, 0);
        repeat (5) @(negedge clk);

        // Overflow: five accepted, sixth and seventh dropped
        push_pixel(24'h123456);
        push_pixel(24'hA5A5A5);
        push_pixel(24'h0F0F0F);
        push_pixel(24'hF0F0F0);
        push_pixel(24'h00FF00);
        check("t3 level full", fifo_level, 4);
        check("t3 no overflow after five", overflow, 0);
        push_pixel(24'h111111);
        check("t3 overflow after sixth", overflow, 1);
        push_pixel(24'h222222);
        check("t3 overflow after seventh", overflow, 1);
        check("t3 level still full", fifo_level, 4);
        @(negedge clk); overflow_clr = 1'b1;
        @(negedge clk); overflow_clr = 1'b0;
        check("t3 overflow cleared", overflow, 0);
        pixel_data = 24'h333333; pixel_push = 1'b1; overflow_clr = 1'b1;
        @(negedge clk); pixel_push = 1'b0; overflow_clr = 1'b0;
        check("t3 drop beats clear", overflow, 1);
        @(negedge clk); overflow_clr = 1'b1;
        @(negedge clk); overflow_clr = 1'b0;
        check("t3 overflow cleared again", overflow, 0);
        wait_busy_low("t3 drained", 6 * PIX_CYC);
        check("t3 level empty", fifo_level, 0);
        repeat (5) @(negedge clk);

        // Latch requested while two pixels are queued
        push_pixel(24'h00FF00);
        push_pixel(24'h5A3C96);
        push_pixel(24'h000081);
        check("t4 two queued", fifo_level, 2);
        @(negedge clk); frame_latch = 1'b1;
        @(negedge clk); frame_latch = 1'b0;
        t = 0; last_rise = -1; hi_after = 0; prev = led_dout;
        while (busy && t < 4 * PIX_CYC + TRESET + 100) begin
            @(negedge clk);
            t++;
            if (led_dout && !prev) begin
                last_rise = t;
                hi_after  = 0;
            end
            if (led_dout) hi_after++;
            prev = led_dout;
        end
        check("t4 busy fell", busy, 0);
        check("t4 last rise to busy fall", t - last_rise, TBIT + 1 + TRESET);
        check("t4 last bit high width", hi_after, T1H);
        repeat (5) @(negedge clk);

        // Push level held high across reset deassert
        pixel_data = 24'hABCDEF; pixel_push = 1'b1; reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t5 no pixel queued", fifo_level, 0);
        check("t5 led stays low", led_dout, 0);
        check("t5 not busy", busy, 0);
        pixel_push = 1'b0;
        repeat (3) @(negedge clk);

        // Reset asserted mid-bit
        push_pixel(24'hFF0000);
        push_pixel(24'h010203);
        push_pixel(24'h040506);
        check("t6 led high before reset", led_dout, 1);
        check("t6 queued before reset", fifo_level, 2);
        #5 reset_n = 1'b0;
        #1;
        check("t6 async led low", led_dout, 0);
        check("t6 async level zero", fifo_level, 0);
        check("t6 async busy low", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        push_pixel(24'h3C00C3);
        @(negedge clk);
        check("t6 resume rise", led_dout, 1);
        capture(PIX_CYC);
        check_bits("t6", {24'h0, 24'h3C00C3}, 24);
        @(negedge clk);
        check("t6 busy falls", busy, 0);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        n_errors++;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
